psum_deskew_collector: RTL

- Sits at the south edge of the systolic MAC array and receives its per-column partial sums.
- Those psums arrive skewed in time: column j's valid pulse comes one cycle after column j-1's.
- The block buffers each column in its own small FIFO and re-aligns the columns into complete rows.
- It presents the aligned rows to the downstream output-SRAM writer through a valid/ready handshake.

---
 rtl/psum_deskew_collector.sv | 109 ++++++++++
 1 files changed

// File: rtl/psum_deskew_collector.sv
// rtl/psum_deskew_collector.sv - per-column psum FIFOs that re-align skewed
// systolic array outputs into complete rows behind a valid/ready handshake.
module psum_deskew_collector #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic [psum_bw*col-1:0]       in_s,
  input  logic [col-1:0]               valid_in,
  output logic [psum_bw*col-1:0]       out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [col-1:0]               col_full,
  output logic [$clog2(depth+1)-1:0]   rows_avail,
  output logic                         overflow
);

  localparam int CW = $clog2(depth + 1);
  localparam int PW = $clog2(depth);
  localparam logic [CW-1:0] FULL_C = CW'(depth);

  logic [psum_bw-1:0] mem_q [col][depth];
  logic [PW-1:0]      wr_ptr_q [col];
  logic [PW-1:0]      wr_ptr_d [col];
  logic [PW-1:0]      rd_ptr_q [col];
  logic [PW-1:0]      rd_ptr_d [col];
  logic [CW-1:0]      count_q  [col];
  logic [CW-1:0]      count_d  [col];
  logic               overflow_q;
  logic               overflow_d;
  logic               pop;
  logic [col-1:0]     wr_en;
  logic [col-1:0]     drop;
  logic [CW-1:0]      rows_min;

  // A row exists only when every column has at least one entry.
  always_comb begin
    out_valid = 1'b1;
    rows_min  = count_q[0];
    col_full  = '0;
    for (int j = 0; j < col; j++) begin
      if (count_q[j] == '0) out_valid = 1'b0;
      if (count_q[j] < rows_min) rows_min = count_q[j];
      col_full[j] = (count_q[j] == FULL_C);
    end
  end

  assign rows_avail = rows_min;
  assign pop        = out_valid & out_ready;
  assign overflow   = overflow_q;

  always_comb begin
    overflow_d = overflow_q;
    wr_en      = '0;
    drop       = '0;
    for (int j = 0; j < col; j++) begin
      // A full column can still take a write when a pop frees its head slot.
      wr_en[j]    = valid_in[j] & ((count_q[j] != FULL_C) | pop) & ~clr;
      drop[j]     = valid_in[j] & (count_q[j] == FULL_C) & ~pop;
      wr_ptr_d[j] = wr_en[j] ? wr_ptr_q[j] + PW'(1) : wr_ptr_q[j];
      rd_ptr_d[j] = pop ? rd_ptr_q[j] + PW'(1) : rd_ptr_q[j];
      count_d[j]  = count_q[j];
      if (wr_en[j] && !pop) count_d[j] = count_q[j] + CW'(1);
      if (!wr_en[j] && pop) count_d[j] = count_q[j] - CW'(1);
      if (clr) begin
        wr_ptr_d[j] = '0;
        rd_ptr_d[j] = '0;
        count_d[j]  = '0;
      end
    end
    if (|drop) overflow_d = 1'b1;
    if (clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      for (int j = 0; j < col; j++) begin
        wr_ptr_q[j] <= '0;
        rd_ptr_q[j] <= '0;
        count_q[j]  <= '0;
      end
    end else begin
      overflow_q <= overflow_d;
      for (int j = 0; j < col; j++) begin
        wr_ptr_q[j] <= wr_ptr_d[j];
        rd_ptr_q[j] <= rd_ptr_d[j];
        count_q[j]  <= count_d[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < col; j++) begin
      if (wr_en[j]) mem_q[j][wr_ptr_q[j]] <= in_s[j*psum_bw +: psum_bw];
    end
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < col; j++) begin
      if (out_valid) out_data[j*psum_bw +: psum_bw] = mem_q[j][rd_ptr_q[j]];
    end
  end

endmodule
